// File: rtl/l2_home_responder_pkg.sv
// Shared types for the L2 home responder: Spandex-style message codes, line geometry,
// FSM states and the request-to-response message mapping.
package l2_home_responder_pkg;

    localparam int unsigned WORDS  = 4;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 28;

    typedef logic [4:0]              coh_msg_t;
    typedef logic [ADDR_W-1:0]       line_addr_t;
    typedef logic [WORDS*WORD_W-1:0] line_t;
    typedef logic [WORDS-1:0]        word_mask_t;
    typedef logic [3:0]              invack_cnt_t;

    localparam coh_msg_t REQ_S      = 5'd1;
    localparam coh_msg_t REQ_O      = 5'd2;
    localparam coh_msg_t REQ_V      = 5'd3;
    localparam coh_msg_t REQ_WT     = 5'd4;
    localparam coh_msg_t REQ_Odata  = 5'd5;
    localparam coh_msg_t REQ_WB     = 5'd6;

    localparam coh_msg_t RSP_S      = 5'd16;
    localparam coh_msg_t RSP_O      = 5'd17;
    localparam coh_msg_t RSP_V      = 5'd18;
    localparam coh_msg_t RSP_WT     = 5'd19;
    localparam coh_msg_t RSP_Odata  = 5'd20;
    localparam coh_msg_t RSP_WB_ACK = 5'd21;

    typedef enum logic [1:0] {StIdle, StWait, StExec, StRsp} home_state_t;

    typedef struct packed {
        coh_msg_t msg;
        logic     unsupported;
    } home_rsp_t;

    function automatic home_rsp_t home_rsp_msg(input coh_msg_t msg);
        home_rsp_t r;
        r.msg         = RSP_V;
        r.unsupported = 1'b0;
        case (msg)
            REQ_V:     r.msg = RSP_V;
            REQ_S:     r.msg = RSP_S;
            REQ_Odata: r.msg = RSP_Odata;
            REQ_O:     r.msg = RSP_O;
            REQ_WT:    r.msg = RSP_WT;
            REQ_WB:    r.msg = RSP_WB_ACK;
            default:   r.unsupported = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/l2_home_responder_if.sv
// L2 request/response channel pair as seen between the L2 core (master) and the home node (slave).
interface l2_home_responder_if;
    import l2_home_responder_pkg::*;

    logic        req_valid;
    logic        req_ready;
    coh_msg_t    req_coh_msg;
    logic [1:0]  req_hprot;
    line_addr_t  req_addr;
    line_t       req_line;
    word_mask_t  req_word_mask;

    logic        rsp_valid;
    logic        rsp_ready;
    coh_msg_t    rsp_coh_msg;
    line_addr_t  rsp_addr;
    line_t       rsp_line;
    word_mask_t  rsp_word_mask;
    invack_cnt_t rsp_invack_cnt;

    logic        err;

    modport master (
        output req_valid, req_coh_msg, req_hprot, req_addr, req_line, req_word_mask, rsp_ready,
        input  req_ready, rsp_valid, rsp_coh_msg, rsp_addr, rsp_line, rsp_word_mask,
               rsp_invack_cnt, err
    );

    modport slave (
        input  req_valid, req_coh_msg, req_hprot, req_addr, req_line, req_word_mask, rsp_ready,
        output req_ready, rsp_valid, rsp_coh_msg, rsp_addr, rsp_line, rsp_word_mask,
               rsp_invack_cnt, err
    );

endinterface

// File: rtl/home_line_mem.sv
// Flop-based line memory with word-masked writes, combinational read and synchronous clear.
module home_line_mem
    import l2_home_responder_pkg::*;
#(
    parameter int unsigned MEM_LINES = 16,
    parameter int unsigned IDX_W     = $clog2(MEM_LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  word_mask_t       i_wmask,
    input  line_t            i_wdata,
    output line_t            o_rdata
);

    line_t r_mem [MEM_LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(MEM_LINES); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int w = 0; w < int'(WORDS); w++) begin
                if (i_wmask[w]) begin
                    r_mem[i_idx][w*WORD_W +: WORD_W] <= i_wdata[w*WORD_W +: WORD_W];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/l2_home_responder.sv
// Home-node stand-in for the LLC: one outstanding request, programmable latency, word-masked
// line memory behind it. Never issues forwards.
module l2_home_responder
    import l2_home_responder_pkg::*;
#(
    parameter int unsigned MEM_LINES = 16,
    parameter int unsigned LAT       = 2
) (
    input logic                clk,
    input logic                rst,
    l2_home_responder_if.slave bus
);

    localparam int unsigned IDX_W   = $clog2(MEM_LINES);
    localparam logic [3:0]  LAT_CNT = 4'(LAT);

    home_state_t r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    coh_msg_t    r_msg;
    logic [1:0]  r_hprot;
    line_addr_t  r_addr;
    line_t       r_line;
    word_mask_t  r_mask;
    logic        r_req_ready;
    logic        r_rsp_valid;
    coh_msg_t    r_rsp_msg;
    line_t       r_rsp_line;
    logic        r_err;

    home_rsp_t   w_dec;
    logic        w_rd;
    logic        w_wr;
    logic        w_mem_we;
    line_t       w_rdata;
    logic        w_unused_hprot;

    assign w_dec          = home_rsp_msg(r_msg);
    assign w_rd           = (r_msg == REQ_V) || (r_msg == REQ_S) || (r_msg == REQ_Odata);
    assign w_wr           = (r_msg == REQ_WT) || (r_msg == REQ_WB);
    assign w_unused_hprot = ^r_hprot;

    home_line_mem #(
        .MEM_LINES (MEM_LINES),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_mem_we),
        .i_idx   (r_addr[IDX_W-1:0]),
        .i_wmask (r_mask),
        .i_wdata (r_line),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mem_we    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.req_valid) begin
                    w_cnt_nxt   = LAT_CNT;
                    w_state_nxt = (LAT_CNT == 4'd0) ? StExec : StWait;
                end
            end
            StWait: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (w_cnt_nxt == 4'd0) begin
                    w_state_nxt = StExec;
                end
            end
            StExec: begin
                w_mem_we    = w_wr;
                w_state_nxt = StRsp;
            end
            StRsp: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_msg       <= '0;
            r_hprot     <= '0;
            r_addr      <= '0;
            r_line      <= '0;
            r_mask      <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_msg   <= '0;
            r_rsp_line  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= (w_state_nxt == StIdle);
            r_rsp_valid <= (w_state_nxt == StRsp);
            if (r_state == StIdle && bus.req_valid) begin
                r_msg   <= bus.req_coh_msg;
                r_hprot <= bus.req_hprot;
                r_addr  <= bus.req_addr;
                r_line  <= bus.req_line;
                r_mask  <= bus.req_word_mask;
            end
            if (r_state == StExec) begin
                r_rsp_msg  <= w_dec.msg;
                r_rsp_line <= w_rd ? w_rdata : '0;
                if (w_dec.unsupported) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Address and mask echo straight from the capture registers; they only change in IDLE.
    assign bus.req_ready      = r_req_ready;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_coh_msg    = r_rsp_msg;
    assign bus.rsp_addr       = r_addr;
    assign bus.rsp_line       = r_rsp_line;
    assign bus.rsp_word_mask  = r_mask;
    assign bus.rsp_invack_cnt = '0;
    assign bus.err            = r_err;

endmodule

// File: doc/l2_home_responder.md
# l2_home_responder

Home-node responder for the L2 request channel. It sits opposite the L2 core: it accepts requests from the L2 `req_out` channel and returns responses on the L2 `rsp_in` channel. A small word-masked line memory backs each request, and response latency is programmable. It is used in block-level benches and FPGA bring-up in place of the LLC. It never issues forwards.

## Interface
- `MEM_LINES`, default 16: number of lines held; power of two, at least 2.
- `LAT`, default 2: extra wait cycles between request capture and memory access; 0 to 15.
- `clk` in, 1: clock.
- `rst` in, 1: synchronous, active-high reset.
- `req_valid` in, 1: request valid (driven by L2 `l2_req_out_valid`).
- `req_ready` out, 1: responder can accept a request.
- `req_coh_msg` in, coh_msg_t: request type.
- `req_hprot` in, 2: protection bits; captured, otherwise ignored.
- `req_addr` in, line_addr_t: line address.
- `req_line` in, line_t: write data.
- `req_word_mask` in, word_mask_t: words targeted by the request.
- `rsp_valid` out, 1: response valid (to `l2_rsp_in_valid`).
- `rsp_ready` in, 1: L2 accepts the response.
- `rsp_coh_msg` out, coh_msg_t: response type.
- `rsp_addr` out, line_addr_t: echoes the captured `req_addr`.
- `rsp_line` out, line_t: line data.
- `rsp_word_mask` out, word_mask_t: echoes the captured `req_word_mask`.
- `rsp_invack_cnt` out, invack_cnt_t: always 0.
- `err` out, 1: sticky flag, set when an unsupported request type is received.

## Operation
- Memory index is `req_addr[$clog2(MEM_LINES)-1:0]`.
  - Higher address bits alias; wrap-around is intended.
- Request-to-response mapping:
  - REQ_V → RSP_V, returns line data.
  - REQ_S → RSP_S, returns line data.
  - REQ_Odata → RSP_Odata, returns line data.
  - REQ_O → RSP_O; `rsp_line` is 0.
  - REQ_WT → RSP_WT; writes the masked words; `rsp_line` is 0.
  - REQ_WB → RSP_WB_ACK; writes the masked words; `rsp_line` is 0.
  - Any other type → RSP_V with `rsp_line` 0; memory is unchanged; `err` is set until reset.
- Writes update only the words whose `word_mask` bit is 1. Words with a mask bit of 0 keep their value.
- Reads return the full stored line. The returned line reflects every write whose response has already handshaken.
- FSM states are IDLE, WAIT, EXEC and RSP.
  - IDLE: `req_ready`=1. On `req_valid`, capture all request fields, load the counter with `LAT`, and go to WAIT (or straight to EXEC if `LAT`=0).
  - WAIT: decrement the counter each cycle; go to EXEC when the counter is 0.
  - EXEC: one cycle. Perform the memory read or write and register the response fields, then go to RSP.
  - RSP: `rsp_valid`=1. Hold every `rsp_*` field stable until `rsp_ready`. On the handshake, go to IDLE.
- Only one request is outstanding at a time. `req_ready` is 0 in WAIT, EXEC and RSP.

## Timing
- A request handshakes in cycle 0. `rsp_valid` rises in cycle `LAT`+2 (cycle 2 when `LAT`=0).
- The earliest next request is accepted in the cycle after the response handshake. Peak throughput is one request per `LAT`+3 cycles.
- `rsp_valid` does not depend combinationally on `rsp_ready`. `req_ready` is a registered decode of the state.
- Reset values:
  - State: IDLE.
  - `req_ready`=1 and `rsp_valid`=0 in the first cycle after `rst` deasserts.
  - All `rsp_*` data outputs are 0; `err`=0.
  - All memory lines are 0.
- Reset asserted mid-operation discards the captured request and any pending response. No partial write survives, because the memory is cleared.
- `rsp_ready` held low keeps the FSM in RSP indefinitely. Outputs stay stable and no new request is accepted.

## Structure
- Shared package, next to the Spandex types:
  - the state enum `home_state_t`;
  - the function `home_rsp_msg(coh_msg_t)`, which returns the response type and an unsupported flag.
- Sub-module `home_line_mem`:
  - `MEM_LINES` × line_t flops;
  - synchronous clear on `rst`;
  - one read or write port per cycle, with word-mask write enables.
- The top level holds the FSM, the capture registers, the counter and the response registers. Target is roughly 200 lines of RTL.

## Test plan
- Reset, then REQ_V addr 0x5 → after the handshake at cycle 0, `rsp_valid` rises at cycle 4 (`LAT`=2) with RSP_V, line all-zero and mask echoed.
- REQ_WT addr 0x3, mask 0b0101, line words {A,B,C,D} → RSP_WT. A following REQ_V addr 0x3 returns {A,0,C,0}.
- REQ_WB addr 0x13 with `MEM_LINES`=16 → aliases to line 3. A REQ_S addr 0x3 then returns the written words with RSP_S.
- Hold `rsp_ready`=0 for 10 cycles during RSP → `rsp_valid` and all data stay stable, `req_ready` stays 0, and a new `req_valid` is not accepted. A single response is produced after `rsp_ready` rises.
- Send an unsupported coh_msg → RSP_V with line 0 and `err`=1. `err` is still 1 after a later valid REQ_V, and clears only on `rst`.
- Assert `rst` in WAIT after a REQ_WT → no response is ever produced. A subsequent REQ_V to that address returns zero.
